// File: rtl/hsem_lock_arb_pkg.sv
// Shared types for the HSEM lock arbiter: request opcodes, response codes and pend states.
package hsem_lock_arb_pkg;

    localparam int NUM_CORES  = 2;
    localparam int PEND_CNT_W = 8;

    typedef enum logic {
        OP_LOCK    = 1'b0,
        OP_RELEASE = 1'b1
    } req_op_e;

    typedef enum logic [1:0] {
        ST_GRANTED = 2'b00,
        ST_BUSY    = 2'b01,
        ST_ERROR   = 2'b10
    } rsp_status_e;

    typedef enum logic {
        PEND_IDLE = 1'b0,
        PEND_WAIT = 1'b1
    } pend_state_e;

endpackage

// File: rtl/hsem_lock_arb_pend_fsm.sv
// Per-core pend tracker: latches the parked LOCK request and counts cycles spent waiting.
module hsem_lock_arb_pend_fsm
    import hsem_lock_arb_pkg::*;
#(
    parameter int SEM_W        = 3,
    parameter int PROCID_W     = 8,
    parameter int PEND_TIMEOUT = 255
) (
    input  logic                hclk,
    input  logic                hresetn,
    input  logic                enter,
    input  logic [SEM_W-1:0]    enter_sem,
    input  logic [PROCID_W-1:0] enter_procid,
    input  logic                grant,
    output logic                pend_active,
    output logic [SEM_W-1:0]    pend_sem,
    output logic [PROCID_W-1:0] pend_procid,
    output logic                timeout
);

    pend_state_e           state_q, state_d;
    logic [SEM_W-1:0]      sem_q, sem_d;
    logic [PROCID_W-1:0]   procid_q, procid_d;
    logic [PEND_CNT_W-1:0] cnt_q, cnt_d;

    assign pend_active = (state_q == PEND_WAIT);
    assign pend_sem    = sem_q;
    assign pend_procid = procid_q;
    // Counter holds the number of pend cycles already finished; the current one is the last allowed.
    assign timeout     = pend_active && (cnt_q == PEND_CNT_W'(PEND_TIMEOUT - 1));

    always_comb begin
        state_d  = state_q;
        sem_d    = sem_q;
        procid_d = procid_q;
        cnt_d    = cnt_q;
        case (state_q)
            PEND_IDLE: begin
                if (enter) begin
                    state_d  = PEND_WAIT;
                    sem_d    = enter_sem;
                    procid_d = enter_procid;
                    cnt_d    = '0;
                end
            end
            PEND_WAIT: begin
                if (grant || timeout) begin
                    state_d = PEND_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = PEND_IDLE;
        endcase
    end

    always_ff @(posedge hclk) begin
        if (!hresetn) begin
            state_q  <= PEND_IDLE;
            sem_q    <= '0;
            procid_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            sem_q    <= sem_d;
            procid_q <= procid_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: rtl/hsem_lock_arb.sv
// Two-core lock arbiter for the HSEM semaphore array: lock/owner state, round-robin contention, responses.
module hsem_lock_arb
    import hsem_lock_arb_pkg::*;
#(
    parameter int SEM_NUM      = 8,
    parameter int PROCID_W     = 8,
    parameter int PEND_TIMEOUT = 255,
    parameter int SEM_W        = $clog2(SEM_NUM)
) (
    input  logic                hclk,
    input  logic                hresetn,
    input  logic                req0_valid,
    output logic                req0_ready,
    input  logic                req0_op,
    input  logic                req0_wait,
    input  logic [SEM_W-1:0]    req0_sem,
    input  logic [PROCID_W-1:0] req0_procid,
    output logic                rsp0_valid,
    output logic [1:0]          rsp0_status,
    input  logic                req1_valid,
    output logic                req1_ready,
    input  logic                req1_op,
    input  logic                req1_wait,
    input  logic [SEM_W-1:0]    req1_sem,
    input  logic [PROCID_W-1:0] req1_procid,
    output logic                rsp1_valid,
    output logic [1:0]          rsp1_status,
    output logic [SEM_NUM-1:0]  sem_lock,
    output logic [SEM_NUM-1:0]  sem_owner_core,
    output logic [SEM_NUM-1:0]  sem_free_pulse,
    output logic                semerr_0,
    output logic                semerr_1
);

    logic [NUM_CORES-1:0] req_valid, req_op, req_wait, req_ready, accept, in_range;
    logic [SEM_W-1:0]     req_sem     [NUM_CORES];
    logic [PROCID_W-1:0]  req_procid  [NUM_CORES];
    logic [NUM_CORES-1:0] pend_active, pend_timeout, pend_enter, pend_grant;
    logic [SEM_W-1:0]     pend_sem    [NUM_CORES];
    logic [PROCID_W-1:0]  pend_procid [NUM_CORES];
    logic [NUM_CORES-1:0] cand_lock, cand_free, own_match, win;
    logic [SEM_W-1:0]     cand_sem    [NUM_CORES];
    logic [PROCID_W-1:0]  cand_pid    [NUM_CORES];

    logic [SEM_NUM-1:0]   lock_q, lock_d, owner_core_q, owner_core_d, free_q, free_d;
    logic [PROCID_W-1:0]  owner_pid_q [SEM_NUM];
    logic [PROCID_W-1:0]  owner_pid_d [SEM_NUM];
    logic [NUM_CORES-1:0] rsp_valid_q, rsp_valid_d, semerr_q, semerr_d;
    rsp_status_e          rsp_status_q [NUM_CORES];
    rsp_status_e          rsp_status_d [NUM_CORES];
    logic                 rr_ptr_q, rr_ptr_d;
    logic                 same_target, tie, winner;

    assign req_valid     = {req1_valid, req0_valid};
    assign req_op        = {req1_op, req0_op};
    assign req_wait      = {req1_wait, req0_wait};
    assign req_sem[0]    = req0_sem;
    assign req_sem[1]    = req1_sem;
    assign req_procid[0] = req0_procid;
    assign req_procid[1] = req1_procid;

    for (genvar gi = 0; gi < NUM_CORES; gi++) begin : g_core
        hsem_lock_arb_pend_fsm #(
            .SEM_W        (SEM_W),
            .PROCID_W     (PROCID_W),
            .PEND_TIMEOUT (PEND_TIMEOUT)
        ) u_pend (
            .hclk         (hclk),
            .hresetn      (hresetn),
            .enter        (pend_enter[gi]),
            .enter_sem    (req_sem[gi]),
            .enter_procid (req_procid[gi]),
            .grant        (pend_grant[gi]),
            .pend_active  (pend_active[gi]),
            .pend_sem     (pend_sem[gi]),
            .pend_procid  (pend_procid[gi]),
            .timeout      (pend_timeout[gi])
        );

        assign req_ready[gi]  = ~pend_active[gi];
        assign accept[gi]     = req_valid[gi] & req_ready[gi];
        assign in_range[gi]   = int'(req_sem[gi]) < SEM_NUM;
        assign own_match[gi]  = lock_q[req_sem[gi]] & (owner_core_q[req_sem[gi]] == 1'(gi))
                              & (owner_pid_q[req_sem[gi]] == req_procid[gi]);
        // A parked request keeps competing every cycle in place of a new one.
        assign cand_sem[gi]   = pend_active[gi] ? pend_sem[gi] : req_sem[gi];
        assign cand_pid[gi]   = pend_active[gi] ? pend_procid[gi] : req_procid[gi];
        assign cand_lock[gi]  = pend_active[gi] | (accept[gi] & (req_op[gi] == OP_LOCK) & in_range[gi]);
        assign cand_free[gi]  = ~lock_q[cand_sem[gi]];
        assign win[gi]        = cand_lock[gi] & cand_free[gi] & (~same_target | (winner == 1'(gi)));
    end

    assign same_target = cand_lock[0] & cand_lock[1] & (cand_sem[0] == cand_sem[1]) & cand_free[0];
    assign tie         = same_target & (pend_active[0] == pend_active[1]);
    assign winner      = tie ? rr_ptr_q : pend_active[1];
    assign rr_ptr_d    = rr_ptr_q ^ tie;

    always_comb begin
        lock_d       = lock_q;
        owner_core_d = owner_core_q;
        owner_pid_d  = owner_pid_q;
        free_d       = '0;
        rsp_valid_d  = '0;
        semerr_d     = '0;
        pend_enter   = '0;
        pend_grant   = '0;
        for (int n = 0; n < NUM_CORES; n++) begin
            rsp_status_d[n] = ST_GRANTED;
        end
        for (int n = 0; n < NUM_CORES; n++) begin
            if (win[n]) begin
                lock_d[cand_sem[n]]       = 1'b1;
                owner_core_d[cand_sem[n]] = 1'(n);
                owner_pid_d[cand_sem[n]]  = cand_pid[n];
                rsp_valid_d[n]            = 1'b1;
                pend_grant[n]             = pend_active[n];
            end else if (pend_active[n]) begin
                if (pend_timeout[n]) begin
                    rsp_valid_d[n]  = 1'b1;
                    rsp_status_d[n] = ST_BUSY;
                end
            end else if (accept[n]) begin
                rsp_valid_d[n] = 1'b1;
                if (!in_range[n]) begin
                    rsp_status_d[n] = ST_ERROR;
                    semerr_d[n]     = (req_op[n] == OP_RELEASE);
                end else if (req_op[n] == OP_LOCK) begin
                    if (own_match[n]) begin
                        rsp_status_d[n] = ST_GRANTED;
                    end else if (req_wait[n]) begin
                        rsp_valid_d[n] = 1'b0;
                        pend_enter[n]  = 1'b1;
                    end else begin
                        rsp_status_d[n] = ST_BUSY;
                    end
                end else if (own_match[n]) begin
                    lock_d[req_sem[n]] = 1'b0;
                    free_d[req_sem[n]] = 1'b1;
                end else begin
                    rsp_status_d[n] = ST_ERROR;
                    semerr_d[n]     = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge hclk) begin
        if (!hresetn) begin
            lock_q       <= '0;
            owner_core_q <= '0;
            free_q       <= '0;
            rsp_valid_q  <= '0;
            semerr_q     <= '0;
            rr_ptr_q     <= 1'b0;
            for (int i = 0; i < SEM_NUM; i++) owner_pid_q[i] <= '0;
            for (int n = 0; n < NUM_CORES; n++) rsp_status_q[n] <= ST_GRANTED;
        end else begin
            lock_q       <= lock_d;
            owner_core_q <= owner_core_d;
            owner_pid_q  <= owner_pid_d;
            free_q       <= free_d;
            rsp_valid_q  <= rsp_valid_d;
            semerr_q     <= semerr_d;
            rr_ptr_q     <= rr_ptr_d;
            rsp_status_q <= rsp_status_d;
        end
    end

    assign req0_ready     = req_ready[0];
    assign req1_ready     = req_ready[1];
    assign rsp0_valid     = rsp_valid_q[0];
    assign rsp1_valid     = rsp_valid_q[1];
    assign rsp0_status    = rsp_status_q[0];
    assign rsp1_status    = rsp_status_q[1];
    assign semerr_0       = semerr_q[0];
    assign semerr_1       = semerr_q[1];
    assign sem_lock       = lock_q;
    assign sem_owner_core = owner_core_q;
    assign sem_free_pulse = free_q;

endmodule

// File: tb/tb_hsem_lock_arb.sv
// Directed scenarios plus random traffic for hsem_lock_arb, checked against a cycle-level semaphore model.
module tb_hsem_lock_arb;

    logic       hclk = 1'b0;
    logic       hresetn = 1'b0;
    logic       req0_valid, req0_op, req0_wait, req1_valid, req1_op, req1_wait;
    logic [2:0] req0_sem, req1_sem;
    logic [7:0] req0_procid, req1_procid;
    logic       req0_ready, req1_ready, rsp0_valid, rsp1_valid, semerr_0, semerr_1;
    logic [1:0] rsp0_status, rsp1_status;
    logic [7:0] sem_lock, sem_owner_core, sem_free_pulse;

    int    tests_run = 0;
    int    tests_failed = 0;
    string phase = "init";

    always #5 hclk = ~hclk;

    hsem_lock_arb dut (
        .hclk(hclk), .hresetn(hresetn),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op), .req0_wait(req0_wait),
        .req0_sem(req0_sem), .req0_procid(req0_procid), .rsp0_valid(rsp0_valid), .rsp0_status(rsp0_status),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op), .req1_wait(req1_wait),
        .req1_sem(req1_sem), .req1_procid(req1_procid), .rsp1_valid(rsp1_valid), .rsp1_status(rsp1_status),
        .sem_lock(sem_lock), .sem_owner_core(sem_owner_core), .sem_free_pulse(sem_free_pulse),
        .semerr_0(semerr_0), .semerr_1(semerr_1)
    );

    // Reference model: who holds each semaphore, who is waiting, and whose turn a tie is.
    bit       m_lock [8];
    bit       m_owner [8];
    bit [7:0] m_pid [8];
    bit       m_pend [2];
    int       m_psem [2];
    bit [7:0] m_ppid [2];
    int       m_pcnt [2];
    bit       m_rr;
    bit       e_rsp_v [2];
    bit [1:0] e_rsp_st [2];
    bit       e_err [2];
    bit [7:0] e_free;
    bit       i_v [2];
    bit       i_op [2];
    bit       i_wt [2];
    int       i_sem [2];
    bit [7:0] i_pid [2];

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s/%s: got 0x%0h expected 0x%0h at %0t", phase, tag, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int s = 0; s < 8; s++) begin
            m_lock[s] = 0; m_owner[s] = 0; m_pid[s] = 0;
        end
        for (int c = 0; c < 2; c++) begin
            m_pend[c] = 0; m_pcnt[c] = 0; e_rsp_v[c] = 0; e_rsp_st[c] = 0; e_err[c] = 0;
            i_v[c] = 0; i_op[c] = 0; i_wt[c] = 0; i_sem[c] = 0; i_pid[c] = 0;
        end
        m_rr = 0;
        e_free = 0;
    endtask

    task automatic model_step();
        bit       lk [8];
        bit       own [8];
        bit [7:0] pid [8];
        bit       acc [2];
        bit       want [2];
        bit       win [2];
        int       wsem [2];
        bit [7:0] wpid [2];
        int       w;
        lk = m_lock; own = m_owner; pid = m_pid;
        e_free = 0;
        for (int c = 0; c < 2; c++) begin
            e_rsp_v[c] = 0; e_rsp_st[c] = 0; e_err[c] = 0;
            acc[c]  = i_v[c] && !m_pend[c];
            want[c] = m_pend[c] || (acc[c] && i_op[c] == 1'b0);
            wsem[c] = m_pend[c] ? m_psem[c] : i_sem[c];
            wpid[c] = m_pend[c] ? m_ppid[c] : i_pid[c];
            win[c]  = want[c] && !lk[wsem[c]];
        end
        if (win[0] && win[1] && wsem[0] == wsem[1]) begin
            if (m_pend[0] != m_pend[1]) w = m_pend[0] ? 0 : 1;
            else begin
                w = int'(m_rr);
                m_rr = !m_rr;
            end
            win[1-w] = 0;
        end
        for (int c = 0; c < 2; c++) begin
            if (win[c]) begin
                m_lock[wsem[c]] = 1; m_owner[wsem[c]] = c[0]; m_pid[wsem[c]] = wpid[c];
                e_rsp_v[c] = 1; e_rsp_st[c] = 2'b00; m_pend[c] = 0;
            end else if (m_pend[c]) begin
                m_pcnt[c]++;
                if (m_pcnt[c] == 255) begin
                    e_rsp_v[c] = 1; e_rsp_st[c] = 2'b01; m_pend[c] = 0;
                end
            end else if (acc[c]) begin
                if (i_op[c] == 1'b0) begin
                    if (lk[i_sem[c]] && own[i_sem[c]] == c[0] && pid[i_sem[c]] == i_pid[c]) begin
                        e_rsp_v[c] = 1; e_rsp_st[c] = 2'b00;
                    end else if (i_wt[c]) begin
                        m_pend[c] = 1; m_psem[c] = i_sem[c]; m_ppid[c] = i_pid[c]; m_pcnt[c] = 0;
                    end else begin
                        e_rsp_v[c] = 1; e_rsp_st[c] = 2'b01;
                    end
                end else if (lk[i_sem[c]] && own[i_sem[c]] == c[0] && pid[i_sem[c]] == i_pid[c]) begin
                    m_lock[i_sem[c]] = 0; e_free[i_sem[c]] = 1;
                    e_rsp_v[c] = 1; e_rsp_st[c] = 2'b00;
                end else begin
                    e_rsp_v[c] = 1; e_rsp_st[c] = 2'b10; e_err[c] = 1;
                end
            end
        end
    endtask

    task automatic compare_all();
        logic [7:0] el, eo;
        for (int s = 0; s < 8; s++) begin
            el[s] = m_lock[s];
            eo[s] = m_lock[s] & m_owner[s];
        end
        check_value("rsp0", {rsp0_valid, rsp0_valid ? rsp0_status : 2'b00},
                    {e_rsp_v[0], e_rsp_v[0] ? e_rsp_st[0] : 2'b00});
        check_value("rsp1", {rsp1_valid, rsp1_valid ? rsp1_status : 2'b00},
                    {e_rsp_v[1], e_rsp_v[1] ? e_rsp_st[1] : 2'b00});
        check_value("ready", {req1_ready, req0_ready}, {!m_pend[1], !m_pend[0]});
        check_value("semerr", {semerr_1, semerr_0}, {e_err[1], e_err[0]});
        check_value("sem_lock", sem_lock, el);
        check_value("owner", sem_owner_core & sem_lock, eo);
        check_value("free_pulse", sem_free_pulse, e_free);
    endtask

    task automatic drive_ports();
        req0_valid = i_v[0]; req0_op = i_op[0]; req0_wait = i_wt[0];
        req0_sem = 3'(i_sem[0]); req0_procid = i_pid[0];
        req1_valid = i_v[1]; req1_op = i_op[1]; req1_wait = i_wt[1];
        req1_sem = 3'(i_sem[1]); req1_procid = i_pid[1];
    endtask

    task automatic run_cycle();
        drive_ports();
        model_step();
        @(posedge hclk);
        #1;
        compare_all();
    endtask

    task automatic step(input bit v0, input bit op0, input bit wt0, input int s0, input bit [7:0] p0,
                        input bit v1, input bit op1, input bit wt1, input int s1, input bit [7:0] p1);
        i_v[0] = v0; i_op[0] = op0; i_wt[0] = wt0; i_sem[0] = s0; i_pid[0] = p0;
        i_v[1] = v1; i_op[1] = op1; i_wt[1] = wt1; i_sem[1] = s1; i_pid[1] = p1;
        run_cycle();
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        hresetn = 1'b0;
        model_clear();
        drive_ports();
        @(posedge hclk);
        #1;
        compare_all();
        hresetn = 1'b1;
    endtask

    initial begin
        int n;
        model_clear();
        drive_ports();
        repeat (2) @(posedge hclk);
        #1;

        phase = "t1";
        do_reset();
        step(1, 0, 0, 3, 8'h11, 0, 0, 0, 0, 0);
        check_value("t1_rsp0", {rsp0_valid, rsp0_status}, 3'b100);
        check_value("t1_lock", sem_lock, 8'h08);
        check_value("t1_owner3", sem_owner_core[3], 1'b0);

        phase = "t2";
        step(0, 0, 0, 0, 0, 1, 0, 0, 3, 8'h22);
        check_value("t2_busy", {rsp1_valid, rsp1_status}, 3'b101);
        step(0, 0, 0, 0, 0, 1, 1, 0, 3, 8'h22);
        check_value("t2_err", {rsp1_valid, rsp1_status, semerr_1}, 4'b1101);
        check_value("t2_lock", sem_lock, 8'h08);

        phase = "t3";
        do_reset();
        step(1, 0, 0, 5, 8'h11, 1, 0, 0, 5, 8'h22);
        check_value("t3_first", {rsp0_status, rsp1_status, sem_owner_core[5]}, 5'b00010);
        step(1, 1, 0, 5, 8'h11, 0, 0, 0, 0, 0);
        step(1, 0, 0, 5, 8'h11, 1, 0, 0, 5, 8'h22);
        check_value("t3_second", {rsp0_status, rsp1_status, sem_owner_core[5]}, 5'b01001);

        phase = "t4";
        do_reset();
        step(1, 0, 0, 2, 8'h11, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1, 0, 1, 2, 8'h22);
        repeat (9) idle();
        check_value("t4_ready1", req1_ready, 1'b0);
        step(1, 1, 0, 2, 8'h11, 0, 0, 0, 0, 0);
        check_value("t4_free", sem_free_pulse, 8'h04);
        idle();
        check_value("t4_grant", {rsp1_valid, rsp1_status, sem_owner_core[2]}, 4'b1001);

        phase = "t5";
        do_reset();
        step(1, 0, 0, 2, 8'h11, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1, 0, 1, 2, 8'h22);
        n = 0;
        for (int k = 1; k <= 400; k++) begin
            idle();
            if (rsp1_valid) begin
                n = k;
                break;
            end
        end
        check_value("t5_cycles", n, 255);
        check_value("t5_busy", {rsp1_status, req1_ready}, 3'b011);

        phase = "t6";
        do_reset();
        for (int s = 0; s < 8; s++) step(1, 0, 0, s, 8'h11, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1, 0, 1, 0, 8'h22);
        repeat (3) idle();
        do_reset();
        check_value("t6_state", {sem_lock, rsp0_valid, rsp1_valid, req0_ready, req1_ready}, 12'h003);

        phase = "rand";
        do_reset();
        for (int k = 0; k < 4000; k++) begin
            if ($urandom_range(0, 999) == 0) begin
                do_reset();
            end else begin
                for (int c = 0; c < 2; c++) begin
                    i_v[c]   = ($urandom_range(0, 9) < 6);
                    i_op[c]  = $urandom_range(0, 1) == 1;
                    i_wt[c]  = ($urandom_range(0, 3) == 0);
                    i_sem[c] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 7)) : int'($urandom_range(0, 2));
                    i_pid[c] = $urandom_range(0, 1) == 1 ? 8'h20 : 8'h10;
                end
                run_cycle();
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
